// File: rtl/unswitch_fifo_pkg.sv
// Shared definitions for the un-swap FIFO and its read-path operand switch.
// The tag encoding must match the operand switch that produced the pairs.
package unswitch_fifo_pkg;

    localparam logic SEL_STRAIGHT = 1'b0;  // operands passed through unchanged
    localparam logic SEL_SWAP     = 1'b1;  // operands were exchanged by the producer

endpackage

// File: rtl/unswitch_fifo_if.sv
// Handshake bundle between producer/consumer (master) and the un-swap FIFO (slave).
interface unswitch_fifo_if #(
    parameter int P_WIDTH = 32,
    parameter int DEPTH   = 4
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [P_WIDTH-1:0] in_a;
    logic [P_WIDTH-1:0] in_b;
    logic               in_sel;
    logic               out_valid;
    logic               out_ready;
    logic [P_WIDTH-1:0] out_a;
    logic [P_WIDTH-1:0] out_b;
    logic               out_sel;
    logic [ADDR_W:0]    count;
    logic               overflow;

    modport master (
        output flush, in_valid, in_a, in_b, in_sel, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_sel, count, overflow
    );

    modport slave (
        input  flush, in_valid, in_a, in_b, in_sel, out_ready,
        output in_ready, out_valid, out_a, out_b, out_sel, count, overflow
    );

endinterface

// File: rtl/unswitch_fifo_switch.sv
// Operand switch: exchanges the two operands when the tag says they were swapped.
// Used on the FIFO read path to restore program order.
module switch
    import unswitch_fifo_pkg::*;
#(
    parameter int P_WIDTH = 32
) (
    input  logic               sel,
    input  logic [P_WIDTH-1:0] ain,
    input  logic [P_WIDTH-1:0] bin,
    output logic [P_WIDTH-1:0] aout,
    output logic [P_WIDTH-1:0] bout
);

    assign aout = (sel == SEL_SWAP) ? bin : ain;
    assign bout = (sel == SEL_SWAP) ? ain : bin;

endmodule

// File: rtl/unswitch_fifo.sv
// First-word-fall-through FIFO holding swapped operand pairs with their swap tag.
// The head entry is un-swapped combinationally, so the consumer sees pairs back in
// the producer's original operand order.
module unswitch_fifo
    import unswitch_fifo_pkg::*;
#(
    parameter int P_WIDTH = 32,
    parameter int DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    unswitch_fifo_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    typedef struct packed {
        logic               sel;
        logic [P_WIDTH-1:0] a;
        logic [P_WIDTH-1:0] b;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              pop;

    // Full/empty come from the occupancy counter alone; pointers just wrap.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    // Storage write at the tail; a flush cycle drops the incoming pair.
    // NOTE: storage has no reset -- contents are only observable while out_valid=1,
    // and every readable slot was written first, so resetting the array buys nothing.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem[wr_ptr] <= '{sel: bus.in_sel, a: bus.in_a, b: bus.in_b};
        end
    end

    // Pointer and occupancy update; flush outranks push/pop, reset outranks flush.
    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // which keeps push and pop at the same edge consistent with each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            if (push && !pop)      count <= count + (ADDR_W+1)'(1);
            else if (pop && !push) count <= count - (ADDR_W+1)'(1);
        end
    end

    // Sticky overflow: a producer offered data while the FIFO was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (bus.in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    assign head = mem[rd_ptr];

    switch #(.P_WIDTH(P_WIDTH)) u_unswap (
        .sel  (head.sel),
        .ain  (head.a),
        .bin  (head.b),
        .aout (bus.out_a),
        .bout (bus.out_b)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sel   = head.sel;
    assign bus.count     = count;
    assign bus.overflow  = overflow;

endmodule

// File: tb/tb_unswitch_fifo.sv
// Self-checking bench for unswitch_fifo: directed table, hand-written corner
// sequences and a long random run against a queue-based reference model.
module tb_unswitch_fifo;
    import unswitch_fifo_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    typedef struct {
        logic         v;
        logic         r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        int           exp_count;
        logic         exp_valid;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unswitch_fifo_if #(.P_WIDTH(W), .DEPTH(DEPTH)) bus ();

    unswitch_fifo #(.P_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_cmp  = 0;
    int    n_fail = 0;
    pair_t mq[$];       // reference contents, already restored to original order
    bit    m_ovf = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic f,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.flush     = f;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sel    = s;
    endtask

    // Advance the model by the rules for this edge, then clock the DUT.
    task automatic tick();
        pair_t p;
        bit    do_push;
        bit    do_pop;
        do_push = bus.in_valid && (mq.size() < DEPTH);
        do_pop  = bus.out_ready && (mq.size() != 0);
        if (bus.in_valid && mq.size() == DEPTH) m_ovf = 1'b1;
        p.a = (bus.in_sel == SEL_SWAP) ? bus.in_b : bus.in_a;
        p.b = (bus.in_sel == SEL_SWAP) ? bus.in_a : bus.in_b;
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"},     64'(bus.count),     64'(mq.size()));
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(mq.size() != 0));
        check({tag, ".in_ready"},  64'(bus.in_ready),  64'(mq.size() != DEPTH));
        check({tag, ".overflow"},  64'(bus.overflow),  64'(m_ovf));
        if (mq.size() != 0) begin
            check({tag, ".out_a"}, 64'(bus.out_a), 64'(mq[0].a));
            check({tag, ".out_b"}, 64'(bus.out_b), 64'(mq[0].b));
        end
    endtask

    vec_t vecs[4];

    initial begin
        int pushed;
        int cyc;

        // Reset state
        drive(1'b0, 1'b0, 1'b0, '0, '0, SEL_STRAIGHT);
        repeat (2) @(posedge clk);
        #1;
        check("reset.count",     64'(bus.count),     64'(0));
        check("reset.out_valid", 64'(bus.out_valid), 64'(0));
        check("reset.in_ready",  64'(bus.in_ready),  64'(1));
        check("reset.overflow",  64'(bus.overflow),  64'(0));
        rst_n = 1'b1;

        // Directed table: straight pair, swapped pair, then two pops
        vecs[0] = '{1'b1, 1'b0, 32'h11, 32'h22, SEL_STRAIGHT, 1, 1'b1, 32'h11, 32'h22};
        vecs[1] = '{1'b1, 1'b0, 32'h33, 32'h44, SEL_SWAP,     2, 1'b1, 32'h11, 32'h22};
        vecs[2] = '{1'b0, 1'b1, 32'h0,  32'h0,  SEL_STRAIGHT, 1, 1'b1, 32'h44, 32'h33};
        vecs[3] = '{1'b0, 1'b1, 32'h0,  32'h0,  SEL_STRAIGHT, 0, 1'b0, 32'h0,  32'h0};
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i].v, vecs[i].r, 1'b0, vecs[i].a, vecs[i].b, vecs[i].s);
            tick();
            check($sformatf("vec%0d.count", i), 64'(bus.count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d.valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d.out_a", i), 64'(bus.out_a), 64'(vecs[i].exp_a));
                check($sformatf("vec%0d.out_b", i), 64'(bus.out_b), 64'(vecs[i].exp_b));
            end
        end

        // Fill to full with the consumer stalled
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'hA0 + 32'(i), 32'hB0 + 32'(i), 1'(i % 2));
            tick();
            check_state("fill");
        end
        check("full.count",    64'(bus.count),    64'(DEPTH));
        check("full.in_ready", 64'(bus.in_ready), 64'(0));
        check("full.overflow", 64'(bus.overflow), 64'(0));
        // Offer while full: overflow sticks, head stays put
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            tick();
            check_state("stall");
            check("stall.head_a", 64'(bus.out_a), 64'(32'hA0));
        end
        // Offer with concurrent pop while full: pop only
        drive(1'b1, 1'b1, 1'b0, 32'hEE, 32'hFF, SEL_STRAIGHT);
        tick();
        check_state("full_pushpop");
        check("full_pushpop.count", 64'(bus.count), 64'(DEPTH - 1));

        // Drain to one entry, then stream across pointer wrap
        while (mq.size() > 1) begin
            drive(1'b0, 1'b1, 1'b0, '0, '0, SEL_STRAIGHT);
            tick();
            check_state("drain1");
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            tick();
            check_state("stream");
            check("stream.count1", 64'(bus.count), 64'(1));
        end

        // Build to three entries, then flush with a concurrent push
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            tick();
            check_state("pre_flush");
        end
        check("pre_flush.count3", 64'(bus.count), 64'(3));
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, SEL_SWAP);
        tick();
        check_state("flush");
        check("flush.count0",   64'(bus.count),     64'(0));
        check("flush.valid0",   64'(bus.out_valid), 64'(0));
        check("flush.ovf_kept", 64'(bus.overflow),  64'(1));
        drive(1'b0, 1'b0, 1'b0, '0, '0, SEL_STRAIGHT);
        tick();
        check_state("post_flush");

        // Asynchronous reset in the middle of traffic
        drive(1'b1, 1'b0, 1'b0, 32'h5, 32'h6, SEL_STRAIGHT);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check_state("async_rst");
        check("async_rst.overflow0", 64'(bus.overflow), 64'(0));
        drive(1'b0, 1'b0, 1'b0, '0, '0, SEL_STRAIGHT);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_state("rst_release");

        // Random traffic against the reference queue
        pushed = 0;
        cyc    = 0;
        while (pushed < 1000 && cyc < 20000) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1'b0,
                  $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            if (bus.in_valid && mq.size() < DEPTH) pushed++;
            tick();
            cyc++;
            check_state("rand");
            check("rand.count_le_depth", 64'(bus.count <= DEPTH), 64'(1));
        end
        check("rand.all_pushed", 64'(pushed >= 1000), 64'(1));
        cyc = 0;
        while (mq.size() != 0 && cyc < 100) begin
            drive(1'b0, 1'b1, 1'b0, '0, '0, SEL_STRAIGHT);
            tick();
            cyc++;
            check_state("drain");
        end
        check("drain.empty", 64'(bus.out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
